// File: rtl/cpu_pkg.sv
// Shared types and encodings for the teaching-CPU control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StCalc,
    StWriteImm,
    StWriteReg
  } state_t;

  typedef enum logic [2:0] {
    ClsUndef,
    ClsMovImm,
    ClsMovReg,
    ClsAdd,
    ClsCmp,
    ClsAnd,
    ClsMvn
  } instr_cls_t;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [1:0] OpMovImm = 2'b10;
  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpCmp    = 2'b01;
  localparam logic [1:0] OpAnd    = 2'b10;
  localparam logic [1:0] OpMvn    = 2'b11;

  localparam logic [1:0] WbDatapath = 2'b00;
  localparam logic [1:0] WbPc       = 2'b01;
  localparam logic [1:0] WbImm8     = 2'b10;
  localparam logic [1:0] WbMdata    = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits the IR into fields, classifies the
// instruction and sign-extends the immediates.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output instr_cls_t  cls_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o
);

  logic [2:0] opcode;

  assign opcode   = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  always_comb begin
    cls_o = ClsUndef;
    case (opcode)
      OpcMov: begin
        if (op_o == OpMovImm) begin
          cls_o = ClsMovImm;
        end else if (op_o == OpMovReg) begin
          cls_o = ClsMovReg;
        end
      end
      OpcAlu: begin
        case (op_o)
          OpAdd:   cls_o = ClsAdd;
          OpCmp:   cls_o = ClsCmp;
          OpAnd:   cls_o = ClsAnd;
          default: cls_o = ClsMvn;
        endcase
      end
      default: cls_o = ClsUndef;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Control unit: instruction register plus multi-cycle Moore FSM driving the datapath.
module cpu_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_i,
  input  logic        load_i,
  input  logic        s_i,
  output logic        w_o,
  output logic [2:0]  r_addr_o,
  output logic [2:0]  w_addr_o,
  output logic        w_en_o,
  output logic        en_a_o,
  output logic        en_b_o,
  output logic        sel_a_o,
  output logic        sel_b_o,
  output logic [1:0]  shift_op_o,
  output logic [1:0]  alu_op_o,
  output logic        en_c_o,
  output logic        en_status_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [1:0]  op;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh;
  instr_cls_t  cls;

  instr_dec u_instr_dec (
    .ir_i     (ir_q),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (sh),
    .rm_o     (rm),
    .cls_o    (cls),
    .sximm8_o (sximm8_o),
    .sximm5_o (sximm5_o)
  );

  // IR only loads in WAIT so fields stay stable for the whole instruction.
  assign ir_d = (state_q == StWait && load_i) ? in_i : ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (s_i) state_d = StDecode;
      StDecode: begin
        unique case (cls)
          ClsMovImm:                state_d = StWriteImm;
          ClsMovReg, ClsMvn:        state_d = StGetB;
          ClsAdd, ClsAnd, ClsCmp:   state_d = StGetA;
          default:                  state_d = StWait;
        endcase
      end
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StCalc;
      StCalc:     state_d = (cls == ClsCmp) ? StWait : StWriteReg;
      StWriteImm: state_d = StWait;
      StWriteReg: state_d = StWait;
      default:    state_d = StWait;
    endcase
  end

  always_comb begin
    w_o         = 1'b0;
    r_addr_o    = '0;
    w_addr_o    = '0;
    w_en_o      = 1'b0;
    en_a_o      = 1'b0;
    en_b_o      = 1'b0;
    sel_a_o     = 1'b0;
    sel_b_o     = 1'b0;
    shift_op_o  = '0;
    alu_op_o    = '0;
    en_c_o      = 1'b0;
    en_status_o = 1'b0;
    wb_sel_o    = WbDatapath;
    unique case (state_q)
      StWait: w_o = 1'b1;
      StGetA: begin
        r_addr_o = rn;
        en_a_o   = 1'b1;
      end
      StGetB: begin
        r_addr_o = rm;
        en_b_o   = 1'b1;
      end
      StCalc, StWriteReg: begin
        shift_op_o = sh;
        en_c_o     = 1'b1;
        // Zero on the A side turns the ALU into a pass/invert of the shifted B.
        sel_a_o    = (cls == ClsMovReg) || (cls == ClsMvn);
        alu_op_o   = (cls == ClsMovReg) ? OpAdd : op;
        if (state_q == StCalc) begin
          en_status_o = (cls == ClsCmp);
        end else begin
          w_addr_o = rd;
          wb_sel_o = WbDatapath;
          w_en_o   = 1'b1;
        end
      end
      StWriteImm: begin
        w_addr_o = rn;
        wb_sel_o = WbImm8;
        w_en_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
